fround_pipe: RTL
================

Name: fround_pipe

Overview:
- Parametrised, pipelined float-to-integral-float rounding unit for the FPU; successor to the single-mode floor block.
- Supports four rounding modes selected per operation: floor, ceil, trunc and round-to-nearest-even.
- Generic exponent/fraction widths, valid/ready handshake with backpressure, and a tag carried alongside each operation.
- Sits beside the other FPU units and issues results into the core's writeback path.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, fraction field width; word width W = 1+EXP_W+FRAC_W
TAG_W, 4, width of the opaque tag carried with each operation

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
op_valid  input  1  operand offered
op_ready  output  1  unit accepts the operand this cycle
op  input  W  IEEE-style operand {sign, exp, frac}
mode  input  2  00 floor, 01 ceil, 10 trunc, 11 RNE
op_tag  input  TAG_W  tag, returned unchanged with the result
result_valid  output  1  result present
result_ready  input  1  consumer accepts the result
result  output  W  rounded value
result_tag  output  TAG_W  tag of the result

Behaviour:
- Handshake: a transfer occurs when valid&&ready on a clock edge. Two register stages: S1 (decode, mask, increment decision) and S2 (add, pack).
- Latency: exactly 2 cycles from op acceptance to result_valid when not stalled. Throughput is 1 op/cycle while result_ready=1.
- Stall rule: S2 holds when result_valid && !result_ready. S1 advances iff S2 is empty or draining. op_ready = !s1_valid || s1_advance, a combinational path from result_ready. No op is ever dropped or duplicated. Held outputs stay stable while stalled.
- Reset (any time, including mid-operation): s1_valid = s2_valid = 0, result_valid = 0, result = 0, result_tag = 0. In-flight ops are discarded.
- Arithmetic: BIAS = 2^(EXP_W-1)-1 and e = exp-BIAS.
  - exp all-ones (Inf/NaN): pass through unchanged.
  - exp = 0 (zero/denormal): flushed to a zero of the same sign.
  - e >= FRAC_W: already integral, pass through.
  - e < 0, nonzero: result is ±0 or ±1.0 (1.0 = {sign, BIAS, 0}):
    - floor: +x gives +0, -x gives -1.0.
    - ceil: +x gives +1.0, -x gives -0.
    - trunc: signed zero.
    - RNE: e = -1 with frac ≠ 0 gives ±1.0; exactly ±0.5 gives signed zero; e < -1 gives signed zero.
  - 0 <= e < FRAC_W: k = FRAC_W-e fractional bits.
    - inexact = |frac[k-1:0]|, guard = frac[k-1], sticky = |frac[k-2:0]| (0 when k=1), lsb = bit k of {1,frac}.
    - Clear the low k fraction bits.
    - inc: floor = sign&inexact; ceil = !sign&inexact; trunc = 0; RNE = guard&(sticky|lsb).
    - If inc, add 2^k to the {exp,frac} field as one unsigned integer; a carry into exp is the correct result (e.g. 1.5 ceil gives 2.0). No overflow is possible because e < FRAC_W.
  - Sign is always preserved, so results such as -0 can occur.
- Mode and tag are sampled with op and travel with it. A mode change between ops takes effect per op, with no flush.

Optional Feature:
- Macro FROUND_FLAGS_EN adds two outputs aligned with result:
  - result_inexact: the rounded value differs from the input (finite, nonzero inputs only).
  - result_invalid: input is a signalling NaN (exp all-ones, frac≠0, frac MSB = 0). The output becomes the quiet NaN: frac MSB set, other bits kept.
  - Both flags reset to 0.
- Without the macro, the ports do not exist, NaNs pass through bit-exact, and no flag logic is built.

Test Plan:
- FP32 defaults, mode sweep, result_ready=1: op 0x3FC00000 (1.5) gives floor 0x3F800000, ceil 0x40000000, trunc 0x3F800000, RNE 0x40000000. Each result appears exactly 2 cycles after acceptance.
- Ties and negatives: 0x40200000 (2.5) RNE gives 0x40000000. 0xBF000000 (-0.5) gives floor 0xBF800000, ceil 0x80000000, RNE 0x80000000.
- Boundaries:
  - 0x7F7FFFFF, 0x4B000001 and 0xFF800000 are unchanged in every mode.
  - 0x00000001 floor gives 0x00000000.
  - 0x80400000 floor gives 0x80000000 (denormal flush).
- Backpressure: stream 8 ops with distinct tags 0..7 while toggling result_ready 1,0,0,1,… Check all 8 results arrive in order with matching tags, op_ready falls once both stages are full, and outputs are stable while stalled.
- Reset mid-flight: assert reset low with 2 ops in the pipe. result_valid drops immediately (asynchronously). After release, no stale result appears and the next op's result comes 2 cycles after its acceptance.
- Random regression: 10,000 random 32-bit ops × 4 modes compared with a reference model. With FROUND_FLAGS_EN, 0x7F800001 gives result 0x7FC00001, invalid=1; 1.5 floor gives inexact=1.

Source files
------------

// File: rtl/fround_pipe.sv
// fround_pipe: two-stage float rounding (floor/ceil/trunc/RNE) with valid/ready and tag.
// S1 decodes, masks and decides the increment; S2 adds and packs.
// Ports: clk, reset (async, active-low)
//        op_valid/op_ready/op/mode/op_tag                    operand side
//        result_valid/result_ready/result/result_tag         result side
// Optional macro FROUND_FLAGS_EN adds result_inexact and result_invalid,
// and quiets signalling NaNs.
module fround_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [EXP_W+FRAC_W:0]   op,
  input  logic [1:0]              mode,
  input  logic [TAG_W-1:0]        op_tag,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [TAG_W-1:0]        result_tag
`ifdef FROUND_FLAGS_EN
  ,
  output logic                    result_inexact,
  output logic                    result_invalid
`endif
);

  localparam int F  = EXP_W + FRAC_W;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] BIAS =
    EXP_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] FW = EW'(FRAC_W);

  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [FRAC_W-1:0] in_frac;

  assign in_sign = op[F];
  assign in_exp  = op[F-1:FRAC_W];
  assign in_frac = op[FRAC_W-1:0];

  logic signed [EW-1:0] e;
  logic [EW-1:0]        k;

  assign e = $signed({2'b00, in_exp})
           - $signed({2'b00, BIAS});
  assign k = EW'(FW - e);

  // One-hot views of the k fractional bits:
  // m = [k-1:0], gk = guard bit, sk = sticky bits, lk = bit k
  logic [FRAC_W:0] m, gk, sk, lk, fx;

  assign m  = ~({(FRAC_W+1){1'b1}} << k);
  assign gk = m ^ (m >> 1);
  assign sk = m >> 1;
  assign lk = {m[FRAC_W-1:0], 1'b1} ^ m;
  assign fx = {1'b1, in_frac};

  logic inexact, guard, sticky, lsb;

  assign inexact = |(fx & m);
  assign guard   = |(fx & gk);
  assign sticky  = |(fx & sk);
  assign lsb     = |(fx & lk);

  logic is_fl, is_ce, is_tr, is_rn;

  assign is_fl = (mode == 2'b00);
  assign is_ce = (mode == 2'b01);
  assign is_tr = (mode == 2'b10);
  assign is_rn = (mode == 2'b11);

  logic inc, up1;

  always_comb begin
    inc = 1'b0;
    up1 = 1'b0;
    unique case (1'b1)
      is_fl: begin
        inc = in_sign & inexact;
        up1 = in_sign;
      end
      is_ce: begin
        inc = ~in_sign & inexact;
        up1 = ~in_sign;
      end
      is_tr: ;
      is_rn: begin
        inc = guard & (sticky | lsb);
        up1 = (&e) & (|in_frac);
      end
      default: ;
    endcase
  end

  logic c_nan, c_zero, c_pass, c_small;

  assign c_nan   = &in_exp;
  assign c_zero  = ~|in_exp;
  assign c_pass  = (e >= FW) & ~c_nan;
  assign c_small = e[EW-1] & ~c_zero;

  logic [F-1:0] d_field, d_add;
`ifdef FROUND_FLAGS_EN
  logic d_inx, d_inv;
`endif

  always_comb begin
    d_field = {in_exp, in_frac};
    d_add   = '0;
`ifdef FROUND_FLAGS_EN
    d_inx   = 1'b0;
    d_inv   = 1'b0;
`endif
    unique case (1'b1)
      c_nan: begin
`ifdef FROUND_FLAGS_EN
        if (|in_frac && !in_frac[FRAC_W-1]) begin
          d_inv = 1'b1;
          d_field[FRAC_W-1] = 1'b1;
        end
`endif
      end
      c_zero: begin
        d_field = '0;
`ifdef FROUND_FLAGS_EN
        d_inx = |in_frac;
`endif
      end
      c_pass: ;
      c_small: begin
        d_field = up1 ? {BIAS, {FRAC_W{1'b0}}} : '0;
`ifdef FROUND_FLAGS_EN
        d_inx = 1'b1;
`endif
      end
      default: begin
        d_field = {in_exp, in_frac & ~m[FRAC_W-1:0]};
        d_add   = inc ? F'(lk) : '0;
`ifdef FROUND_FLAGS_EN
        d_inx   = inexact;
`endif
      end
    endcase
  end

  logic             s1_valid, s1_sign;
  logic [F-1:0]     s1_field, s1_add;
  logic [TAG_W-1:0] s1_tag;
`ifdef FROUND_FLAGS_EN
  logic             s1_inx, s1_inv;
`endif

  logic s2_free;

  assign s2_free  = !result_valid || result_ready;
  assign op_ready = !s1_valid || s2_free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_field <= '0;
      s1_add   <= '0;
      s1_tag   <= '0;
`ifdef FROUND_FLAGS_EN
      s1_inx   <= 1'b0;
      s1_inv   <= 1'b0;
`endif
    end else if (op_ready) begin
      s1_valid <= op_valid;
      if (op_valid) begin
        s1_sign  <= in_sign;
        s1_field <= d_field;
        s1_add   <= d_add;
        s1_tag   <= op_tag;
`ifdef FROUND_FLAGS_EN
        s1_inx   <= d_inx;
        s1_inv   <= d_inv;
`endif
      end
    end
  end

  // e < FRAC_W guarantees the sum never leaves the F-bit field
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_valid <= 1'b0;
      result       <= '0;
      result_tag   <= '0;
`ifdef FROUND_FLAGS_EN
      result_inexact <= 1'b0;
      result_invalid <= 1'b0;
`endif
    end else if (s2_free) begin
      result_valid <= s1_valid;
      if (s1_valid) begin
        result     <= {s1_sign, s1_field + s1_add};
        result_tag <= s1_tag;
`ifdef FROUND_FLAGS_EN
        result_inexact <= s1_inx;
        result_invalid <= s1_inv;
`endif
      end
    end
  end

endmodule
